// File: rtl/line_buffer_ring.sv
// line_buffer_ring: circular line store emitting K x n tiles stepped by STRIDE, zero-padded past the right edge
module line_buffer_ring #(
  parameter int DW = 8,
  parameter int W = 512,
  parameter int ROWS = 4,
  parameter int K = 3,
  parameter int n = 4,
  parameter int STRIDE = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [DW-1:0]              i_data,
  input  logic                       i_data_valid,
  output logic                       o_ready,
  input  logic                       i_rd_data,
  output logic                       o_tile_ready,
  output logic [K*n*DW-1:0]          o_data,
  output logic                       o_data_valid,
  output logic                       o_line_done,
  output logic [$clog2(ROWS+1)-1:0]  o_lines_full
);
  localparam int CW = W > 1 ? $clog2(W) : 1;
  localparam int LW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + 1);
  logic [DW-1:0] mem [ROWS][W];
  logic [LW-1:0] wr_line, rd_line;
  logic [CW-1:0] wr_col, rd_col;
  logic [FW-1:0] lines_full;
  logic [K*n*DW-1:0] tile;
  logic wr_acc, rd_acc, wr_eol, rd_last;
  assign o_ready      = lines_full < FW'(ROWS);
  assign o_tile_ready = lines_full >= FW'(K);
  assign o_lines_full = lines_full;
  assign wr_acc       = i_data_valid && o_ready;
  assign rd_acc       = i_rd_data && o_tile_ready;
  assign wr_eol       = wr_col == CW'(W - 1);
  assign rd_last      = 32'(rd_col) + n >= W;
  for (genvar i = 0; i < K; i++) begin : g_row
    for (genvar j = 0; j < n; j++) begin : g_col
      logic [LW-1:0] row;
      logic [CW:0] col;
      assign row = LW'((32'(rd_line) + i) % ROWS);
      assign col = {1'b0, rd_col} + (CW+1)'(j);
      assign tile[((K-1-i)*n + (n-1-j))*DW +: DW] = col >= (CW+1)'(W) ? '0 : mem[row][col[CW-1:0]];
    end
  end
  always_ff @(posedge i_clk)
    if (wr_acc) mem[wr_line][wr_col] <= i_data;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_line      <= '0;
      rd_line      <= '0;
      wr_col       <= '0;
      rd_col       <= '0;
      lines_full   <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_line_done  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_col <= wr_eol ? '0 : wr_col + CW'(1);
        if (wr_eol) wr_line <= LW'((32'(wr_line) + 1) % ROWS);
      end
      if (rd_acc) begin
        o_data <= tile;
        rd_col <= rd_last ? '0 : rd_col + CW'(STRIDE);
        if (rd_last) rd_line <= LW'((32'(rd_line) + STRIDE) % ROWS);
      end
      o_data_valid <= rd_acc;
      o_line_done  <= rd_acc && rd_last;
      lines_full   <= lines_full + FW'(wr_acc && wr_eol) - (rd_acc && rd_last ? FW'(STRIDE) : FW'(0));
    end
endmodule
